// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding and
// default sizing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_ARB       = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_e;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_PAYLOAD_BITS = 8;
    localparam int DEF_BUSY_TIMEOUT = 15;

endpackage : uart_pkg

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter with owner lock: while locked only the
// owner may win, otherwise the search starts at ptr and wraps.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 lock,
    input  logic [$clog2(N)-1:0] owner,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_vld
);

    localparam int IW = $clog2(N);

    logic [IW:0]   sum_s;
    logic [IW-1:0] cand_s;
    logic          hit_s;

    // Pick the owner when locked, else the first requester at or after ptr.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        if (lock) begin
            gnt[owner] = req[owner];
            gnt_idx    = owner;
            gnt_vld    = req[owner];
        end else begin
            for (int k = 0; k < N; k++) begin
                sum_s   = {1'b0, ptr} + (IW+1)'(k);
                sum_s   = (sum_s >= (IW+1)'(N)) ? (sum_s - (IW+1)'(N)) : sum_s;
                cand_s  = sum_s[IW-1:0];
                hit_s   = !gnt_vld && req[cand_s];
                gnt[cand_s] = gnt[cand_s] | hit_s;
                gnt_idx = hit_s ? cand_s : gnt_idx;
                gnt_vld = gnt_vld | hit_s;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/uart_tx_sched.sv
// Schedules bytes from several requesters onto one UART transmitter, keeping
// multi-byte messages atomic and recovering if the transmitter never goes busy.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    input  logic                            uart_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            grant_lock,
    output logic                            err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    sched_state_e            state_r;
    logic [IW-1:0]           rr_ptr_r;
    logic [CW-1:0]           wait_cnt_r;
    logic                    last_r;

    logic [NUM_REQ-1:0]      gnt_s;
    logic [IW-1:0]           gnt_idx_s;
    logic                    gnt_vld_s;
    logic                    accept_s;
    logic [PAYLOAD_BITS-1:0] sel_data_s;
    logic                    sel_last_s;
    logic [IW-1:0]           next_ptr_s;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_r),
        .lock    (grant_lock),
        .owner   (grant_id),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_vld (gnt_vld_s)
    );

    // Mealy handshake: ready only while arbitrating, out of reset and with the transmitter free.
    always_comb begin
        accept_s   = (state_r == ST_ARB) && !uart_tx_busy && rst && gnt_vld_s;
        req_ready  = accept_s ? gnt_s : '0;
        sel_data_s = '0;
        sel_last_s = |(gnt_s & req_last);
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_data_s = sel_data_s | (req_data[k*PAYLOAD_BITS +: PAYLOAD_BITS] & {PAYLOAD_BITS{gnt_s[k]}});
        end
        next_ptr_s = (grant_id == IW'(NUM_REQ - 1)) ? '0 : (grant_id + IW'(1));
    end

    // Scheduler FSM with registered strobe, data, owner and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_ARB;
            rr_ptr_r     <= '0;
            grant_id     <= '0;
            grant_lock   <= 1'b0;
            wait_cnt_r   <= '0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            err_timeout  <= 1'b0;
            last_r       <= 1'b0;
        end else begin
            uart_tx_en  <= 1'b0;
            err_timeout <= 1'b0;
            case (state_r)
                ST_ARB: begin
                    if (accept_s) begin
                        uart_tx_data <= sel_data_s;
                        last_r       <= sel_last_s;
                        grant_id     <= gnt_idx_s;
                        uart_tx_en   <= 1'b1;
                        state_r      <= ST_ISSUE;
                    end else begin
                        state_r <= ST_ARB;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_r <= '0;
                    state_r    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (uart_tx_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (wait_cnt_r == CW'(BUSY_TIMEOUT)) begin
                        // Transmitter never acknowledged: drop the message and move on.
                        err_timeout <= 1'b1;
                        grant_lock  <= 1'b0;
                        rr_ptr_r    <= next_ptr_s;
                        state_r     <= ST_ARB;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        if (last_r) begin
                            grant_lock <= 1'b0;
                            rr_ptr_r   <= next_ptr_s;
                        end else begin
                            grant_lock <= 1'b1;
                        end
                        state_r <= ST_ARB;
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    state_r <= ST_ARB;
                end
            endcase
        end
    end

endmodule : uart_tx_sched
